// File: rtl/l0_ctrl_pkg.sv
// Shared types and default constants for the L0 fetch-buffer flush controller.
package l0_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_INVAL = 2'd2,
    ST_ACK   = 2'd3
  } l0_flush_state_e;

  localparam int L0_NB_ENTRIES_DEF = 4;
  localparam int L0_CNT_WIDTH_DEF  = 32;

endpackage

// File: rtl/l0_ctrl_responder_stall_counter.sv
// Saturating fetch-stall cycle counter; synchronous clear wins over increment.
module l0_stall_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/l0_ctrl_responder.sv
// L0 fetch-buffer flush responder: drain refills, sweep-invalidate every entry, then
// four-phase ack. Optional stall counter is built only when L0_STALL_CNT_EN is defined.
module l0_ctrl_responder
  import l0_ctrl_pkg::*;
#(
  parameter int NB_ENTRIES = L0_NB_ENTRIES_DEF,
  parameter int CNT_WIDTH  = L0_CNT_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_FetchBuffer_i,
  output logic                          flush_ack_o,
  output logic [CNT_WIDTH-1:0]          ctrl_stall_count_o,
  input  logic                          stall_cnt_clr_i,
  input  logic                          fetch_req_i,
  input  logic                          fetch_gnt_i,
  input  logic                          refill_pending_i,
  output logic                          prefetch_block_o,
  output logic                          inv_req_o,
  output logic [$clog2(NB_ENTRIES)-1:0] inv_idx_o
);

  localparam int IDX_W = $clog2(NB_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_ENTRIES - 1);

  l0_flush_state_e  state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Once past IDLE the flush always runs to completion; only ACK looks at the request again.
  always_comb begin
    state_d = state_q;
    sweep_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_FetchBuffer_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!refill_pending_i) state_d = ST_INVAL;
      end
      ST_INVAL: begin
        if (sweep_q == LAST_IDX) begin
          state_d = ST_ACK;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      ST_ACK: begin
        if (!flush_FetchBuffer_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore decodes of the state register only.
  assign prefetch_block_o = (state_q != ST_IDLE);
  assign inv_req_o        = (state_q == ST_INVAL);
  assign flush_ack_o      = (state_q == ST_ACK);
  assign inv_idx_o        = inv_req_o ? sweep_q : '0;

`ifdef L0_STALL_CNT_EN
  l0_stall_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fetch_req_i && !fetch_gnt_i),
    .clr   (stall_cnt_clr_i),
    .count (ctrl_stall_count_o)
  );
`else
  assign ctrl_stall_count_o = '0;
  logic unused_stall_inputs;
  assign unused_stall_inputs = &{1'b0, stall_cnt_clr_i, fetch_req_i, fetch_gnt_i};
`endif

endmodule

// File: tb/tb_l0_ctrl_responder.sv
// Directed bench for l0_ctrl_responder (NB_ENTRIES=4, CNT_WIDTH=4); stall checks follow L0_STALL_CNT_EN.
module tb_l0_ctrl_responder;

  localparam int NB = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_FetchBuffer_i;
  logic          flush_ack_o;
  logic [CW-1:0] ctrl_stall_count_o;
  logic          stall_cnt_clr_i;
  logic          fetch_req_i;
  logic          fetch_gnt_i;
  logic          refill_pending_i;
  logic          prefetch_block_o;
  logic          inv_req_o;
  logic [1:0]    inv_idx_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  l0_ctrl_responder #(
    .NB_ENTRIES (NB),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush_FetchBuffer_i (flush_FetchBuffer_i),
    .flush_ack_o         (flush_ack_o),
    .ctrl_stall_count_o  (ctrl_stall_count_o),
    .stall_cnt_clr_i     (stall_cnt_clr_i),
    .fetch_req_i         (fetch_req_i),
    .fetch_gnt_i         (fetch_gnt_i),
    .refill_pending_i    (refill_pending_i),
    .prefetch_block_o    (prefetch_block_o),
    .inv_req_o           (inv_req_o),
    .inv_idx_o           (inv_idx_o)
  );

  // Advance one clock and sample 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected Moore outputs: {ack, block, inv_req, idx}.
  task automatic chk_out(input string tag, input logic ack, input logic blk,
                         input logic inv, input logic [1:0] idx);
    chk(tag, {27'd0, flush_ack_o, prefetch_block_o, inv_req_o, inv_idx_o},
        {27'd0, ack, blk, inv, idx});
  endtask

  initial begin
    rst_n               = 1'b0;
    flush_FetchBuffer_i = 1'b0;
    stall_cnt_clr_i     = 1'b0;
    fetch_req_i         = 1'b0;
    fetch_gnt_i         = 1'b0;
    refill_pending_i    = 1'b0;
    #23;
    chk_out("reset_outputs", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("reset_count", 32'(ctrl_stall_count_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_out("idle_after_reset", 1'b0, 1'b0, 1'b0, 2'd0);

    // Basic flush with no refill outstanding.
    flush_FetchBuffer_i = 1'b1;
    tick();
    chk_out("basic_drain_c1", 1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < NB; i++) begin
      tick();
      chk_out($sformatf("basic_inval_idx%0d", i), 1'b0, 1'b1, 1'b1, 2'(i));
    end
    tick();
    chk_out("basic_ack_c6", 1'b1, 1'b1, 1'b0, 2'd0);
    tick();
    chk_out("basic_ack_hold", 1'b1, 1'b1, 1'b0, 2'd0);
    flush_FetchBuffer_i = 1'b0;
    tick();
    chk_out("basic_idle", 1'b0, 1'b0, 1'b0, 2'd0);

    // Refill pending for the first five DRAIN cycles.
    refill_pending_i    = 1'b1;
    flush_FetchBuffer_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk_out($sformatf("pend_drain_c%0d", c), 1'b0, 1'b1, 1'b0, 2'd0);
    end
    refill_pending_i = 1'b0;
    for (int i = 0; i < NB; i++) begin
      tick();
      chk_out($sformatf("pend_inval_idx%0d", i), 1'b0, 1'b1, 1'b1, 2'(i));
    end
    tick();
    chk_out("pend_ack", 1'b1, 1'b1, 1'b0, 2'd0);
    flush_FetchBuffer_i = 1'b0;
    tick();
    chk_out("pend_idle", 1'b0, 1'b0, 1'b0, 2'd0);

    // Request withdrawn while sweeping index 1.
    flush_FetchBuffer_i = 1'b1;
    tick();
    chk_out("wd_drain", 1'b0, 1'b1, 1'b0, 2'd0);
    tick();
    chk_out("wd_idx0", 1'b0, 1'b1, 1'b1, 2'd0);
    tick();
    chk_out("wd_idx1", 1'b0, 1'b1, 1'b1, 2'd1);
    flush_FetchBuffer_i = 1'b0;
    tick();
    chk_out("wd_idx2", 1'b0, 1'b1, 1'b1, 2'd2);
    tick();
    chk_out("wd_idx3", 1'b0, 1'b1, 1'b1, 2'd3);
    tick();
    chk_out("wd_ack_once", 1'b1, 1'b1, 1'b0, 2'd0);
    tick();
    chk_out("wd_idle", 1'b0, 1'b0, 1'b0, 2'd0);

`ifdef L0_STALL_CNT_EN
    // Saturation at 15 for a 4-bit counter, then clear beating a simultaneous stall.
    fetch_req_i = 1'b1;
    fetch_gnt_i = 1'b0;
    tick();
    chk("stall_first", 32'(ctrl_stall_count_o), 32'd1);
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (c == 15) chk("stall_at15", 32'(ctrl_stall_count_o), 32'd15);
    end
    chk("stall_saturated", 32'(ctrl_stall_count_o), 32'd15);
    stall_cnt_clr_i = 1'b1;
    tick();
    chk("stall_clr_priority", 32'(ctrl_stall_count_o), 32'd0);
    stall_cnt_clr_i = 1'b0;
    fetch_gnt_i     = 1'b1;
    tick();
    chk("stall_granted_no_inc", 32'(ctrl_stall_count_o), 32'd0);
    fetch_gnt_i = 1'b0;
    tick();
    tick();
    chk("stall_resume", 32'(ctrl_stall_count_o), 32'd2);
    fetch_req_i = 1'b0;
`else
    // Counter absent: stall cycles must leave the output at zero.
    fetch_req_i = 1'b1;
    fetch_gnt_i = 1'b0;
    for (int c = 1; c <= 10; c++) tick();
    chk("stall_disabled", 32'(ctrl_stall_count_o), 32'd0);
    stall_cnt_clr_i = 1'b1;
    tick();
    chk("stall_disabled_clr", 32'(ctrl_stall_count_o), 32'd0);
    stall_cnt_clr_i = 1'b0;
    fetch_req_i     = 1'b0;
`endif

    // Asynchronous reset in the middle of the sweep.
    flush_FetchBuffer_i = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk_out("rst_pre_idx2", 1'b0, 1'b1, 1'b1, 2'd2);
    flush_FetchBuffer_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async_outputs", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("rst_async_count", 32'(ctrl_stall_count_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk($sformatf("post_rst_no_ack_c%0d", c), {31'd0, flush_ack_o}, 32'd0);
    end
    chk_out("post_rst_idle", 1'b0, 1'b0, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
